// File: rtl/revo_word_generator_if.sv
// revo_word_generator_if: control inputs and serializer-word outputs of the revolution-marker generator
interface revo_word_generator_if #(
    parameter int WORD_CW = 11,
    parameter int BIT_CW  = 14
);
    logic               i_enable;
    logic [BIT_CW-1:0]  i_bit_offset;
    logic [3:0]         i_pulse_width;
    logic               i_sync_in;
    logic [7:0]         o_word_out;
    logic [WORD_CW-1:0] o_word_index;
    logic               o_revo_out;
    logic               o_aligned;
    logic               o_config_error;
    modport master (
        output i_enable, i_bit_offset, i_pulse_width, i_sync_in,
        input  o_word_out, o_word_index, o_revo_out, o_aligned, o_config_error
    );
    modport slave (
        input  i_enable, i_bit_offset, i_pulse_width, i_sync_in,
        output o_word_out, o_word_index, o_revo_out, o_aligned, o_config_error
    );
endinterface

// File: rtl/revo_word_generator.sv
// revo_word_generator: per-word revolution marker pulse generator; REVO_WORD_GENERATOR_SYNC_EN enables re-phasing to sync_in
module revo_word_generator #(
    parameter int WORDS_PER_REVO = 1280,
    parameter int WORD_CW        = 11,
    parameter int BIT_CW         = 14
) (
    input logic                  i_clock,
    input logic                  i_reset,
    revo_word_generator_if.slave bif
);
    localparam int          BIT_DEPTH  = 8;
    localparam int unsigned TOTAL_BITS = WORDS_PER_REVO * BIT_DEPTH;
    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t             r_state, w_state_nx;
    logic [WORD_CW-1:0] r_cnt, w_cnt_nx;
    logic [BIT_CW-1:0]  r_off, w_off;
    logic [3:0]         r_wid, w_wid;
    logic [7:0]         r_word, w_word;
    logic [WORD_CW-1:0] r_idx;
    logic               r_revo, r_aligned, r_err;
    logic               w_last, w_latch, w_off_ok, w_sync_edge, w_aligned_nx;
    logic [31:0]        w_rel [BIT_DEPTH];
`ifdef REVO_WORD_GENERATOR_SYNC_EN
    logic r_s1, r_s2;
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= bif.i_sync_in;
            r_s2 <= r_s1;
        end
    end
    assign w_sync_edge = bif.i_enable && r_s1 && !r_s2;
`else
    assign w_sync_edge = 1'b0;
`endif
    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nx;
    end
    always_comb begin
        w_state_nx   = bif.i_enable ? S_RUN : S_IDLE;
        w_last       = r_cnt == WORD_CW'(WORDS_PER_REVO - 1);
        w_latch      = bif.i_enable && (r_state == S_IDLE || r_cnt == '0);
        w_off_ok     = 32'(bif.i_bit_offset) < TOTAL_BITS;
        w_off        = (w_latch && w_off_ok) ? bif.i_bit_offset : r_off;
        w_wid        = (w_latch && w_off_ok) ? bif.i_pulse_width : r_wid;
        w_cnt_nx     = (!bif.i_enable || w_last || w_sync_edge) ? '0 : r_cnt + 1'b1;
        w_aligned_nx = !bif.i_enable ? 1'b0 : w_sync_edge ? w_last : r_aligned;
    end
    // bit k of this word sits at revolution bit cnt*8+k; distance past the offset is taken mod TOTAL_BITS
    for (genvar k = 0; k < BIT_DEPTH; k++) begin : g_bit
        assign w_rel[k] = 32'(r_cnt) * BIT_DEPTH + k + TOTAL_BITS - 32'(w_off);
        assign w_word[BIT_DEPTH-1-k] =
            ((w_rel[k] >= TOTAL_BITS) ? w_rel[k] - TOTAL_BITS : w_rel[k]) < 32'(w_wid);
    end
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_off     <= '0;
            r_wid     <= '0;
            r_word    <= '0;
            r_idx     <= '0;
            r_revo    <= 1'b0;
            r_aligned <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nx;
            r_off     <= w_off;
            r_wid     <= w_wid;
            r_word    <= bif.i_enable ? w_word : '0;
            r_idx     <= bif.i_enable ? r_cnt : '0;
            r_revo    <= bif.i_enable && r_cnt == '0;
            r_aligned <= w_aligned_nx;
            r_err     <= r_err || (w_latch && !w_off_ok);
        end
    end
    assign bif.o_word_out     = r_word;
    assign bif.o_word_index   = r_idx;
    assign bif.o_revo_out     = r_revo;
    assign bif.o_aligned      = r_aligned;
    assign bif.o_config_error = r_err;
endmodule

// File: tb/tb_revo_word_generator.sv
// tb_revo_word_generator: scoreboard bench comparing the generator against a rule-based revolution model
module tb_revo_word_generator;
    localparam int WPR   = 4;
    localparam int TOTAL = WPR * 8;
`ifdef REVO_WORD_GENERATOR_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif
    typedef struct packed {
        logic [7:0] word;
        logic [1:0] idx;
        logic       revo;
        logic       aligned;
        logic       err;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    revo_word_generator_if #(.WORD_CW(2), .BIT_CW(6)) bif();
    revo_word_generator #(.WORDS_PER_REVO(WPR), .WORD_CW(2), .BIT_CW(6)) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bif(bif)
    );
    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   m_pos = 0, m_off = 0, m_wid = 0;
    bit   m_err = 0, m_aligned = 0, m_s1 = 0, m_s2 = 0;
    function automatic logic [7:0] ref_word(int pos, int off, int wid);
        logic [7:0] w = '0;
        for (int k = 0; k < 8; k++)
            if ((((pos * 8 + k - off) % TOTAL) + TOTAL) % TOTAL < wid) w[7-k] = 1'b1;
        return w;
    endfunction
    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask
    task automatic step(bit en, int off, int wid, bit sync, bit r);
        exp_t e = '0;
        bit   sedge;
        rst = r;
        bif.i_enable = en;
        bif.i_bit_offset = 6'(off);
        bif.i_pulse_width = 4'(wid);
        bif.i_sync_in = sync;
        if (r) begin
            m_pos = 0; m_off = 0; m_wid = 0;
            m_err = 0; m_aligned = 0; m_s1 = 0; m_s2 = 0;
        end else begin
            sedge = SYNC && en && m_s1 && !m_s2;
            if (!en) begin
                m_aligned = 0;
                m_pos = 0;
            end else begin
                if (m_pos == 0) begin
                    if (off < TOTAL) begin
                        m_off = off;
                        m_wid = wid;
                    end else m_err = 1;
                end
                e.word = ref_word(m_pos, m_off, m_wid);
                e.idx = 2'(m_pos);
                e.revo = (m_pos == 0);
                if (sedge) m_aligned = (m_pos == WPR - 1);
                m_pos = sedge ? 0 : (m_pos + 1) % WPR;
                e.aligned = m_aligned;
            end
            e.err = m_err;
            m_s2 = m_s1;
            m_s1 = sync;
        end
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("word_out", 32'(bif.o_word_out), 32'(e.word));
                chk("word_index", 32'(bif.o_word_index), 32'(e.idx));
                chk("revo_out", 32'(bif.o_revo_out), 32'(e.revo));
                chk("aligned", 32'(bif.o_aligned), 32'(e.aligned));
                chk("config_error", 32'(bif.o_config_error), 32'(e.err));
            end
        end
    end
    initial begin : stim
        step(1, 0, 8, 0, 1);
        step(1, 0, 8, 0, 1);
        repeat (12) step(1, 0, 8, 0, 0);
        repeat (8) step(1, 6, 4, 0, 0);
        repeat (8) step(1, 30, 4, 0, 0);
        repeat (8) step(1, 30, 0, 0, 0);
        repeat (6) step(1, 6, 4, 0, 0);
        repeat (8) step(1, 40, 4, 0, 0);
        step(1, 40, 4, 0, 1);
        repeat (6) step(1, 6, 4, 0, 0);
        for (int i = 0; i < 8 && m_pos != 0; i++) step(1, 6, 4, 0, 0);
        step(1, 6, 4, 1, 0);
        repeat (3) step(1, 6, 4, 0, 0);
        step(1, 6, 4, 1, 0);
        repeat (6) step(1, 6, 4, 0, 0);
        repeat (6) step(1, 6, 4, 1, 0);
        for (int i = 0; i < 8 && m_pos != 3; i++) step(1, 30, 4, 0, 0);
        step(0, 30, 4, 0, 0);
        step(0, 30, 4, 1, 0);
        repeat (6) step(1, 30, 4, 0, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 15) != 0,
                 ($urandom_range(0, 9) == 0) ? 32 + $urandom_range(0, 31) : $urandom_range(0, 31),
                 $urandom_range(0, 15), $urandom_range(0, 5) == 0, $urandom_range(0, 63) == 0);
        @(negedge clk);
        #1;
        chk("scoreboard_drain", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
